// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit feeding the HI/LO register file.
//   MULT/MULTU/DIV/DIVU run over WIDTH+2 cycles on operand magnitudes with a
//   final sign-fix cycle; MTHI/MTLO are passed through with a one-cycle write.
// Ports:
//   clk, rst (async, active low)
//   start, op[2:0], cancel      request / opcode / synchronous abort
//   a, b [WIDTH-1:0]            rs / rt operands
//   busy                        unit occupied with a multi-cycle op
//   hi_out, lo_out [WIDTH-1:0]  registered HI/LO write data
//   hl_write[1:0]               [1]=write HI, [0]=write LO, one-cycle pulse
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [1:0]       hl_write
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [1:0]       hl_q;
    logic             is_div_q;   // 1: divide, 0: multiply
    logic             neg_q;      // product / quotient must be negated
    logic             rneg_q;     // remainder must be negated (dividend sign)
    logic             divz_q;     // divide by zero
    logic [WIDTH-1:0] a_q;        // original dividend, for divide-by-zero
    logic [WIDTH-1:0] opnd_q;     // |a| for multiply, |b| for divide
    logic [WIDTH-1:0] acc_hi_q;   // partial product high / remainder
    logic [WIDTH-1:0] acc_lo_q;   // multiplier shifting out / dividend -> quotient

    // Operand magnitudes at issue time
    logic             op_signed;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign op_signed = ~op[0];
    assign abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;

    // One shift-add multiply step
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // One restoring divide step; extra top bit of the difference is the borrow
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_ok    = ~div_diff[WIDTH+1];

    // A successful trial leaves a remainder below the divisor, so bit WIDTH is always 0
    logic unused_div_bit;
    assign unused_div_bit = div_diff[WIDTH];

    logic [WIDTH-1:0] step_hi_d, step_lo_d;
    assign step_hi_d = is_div_q ? (div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0])
                                : mul_sum[WIDTH:1];
    assign step_lo_d = is_div_q ? {acc_lo_q[WIDTH-2:0], div_ok}
                                : {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Sign correction applied on the FIX -> DONE edge
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_neg = -prod;

    always_comb begin
        fix_hi_d = acc_hi_q;
        fix_lo_d = acc_lo_q;
        if (!is_div_q) begin
            {fix_hi_d, fix_lo_d} = neg_q ? prod_neg : prod;
        end else if (divz_q) begin
            fix_hi_d = a_q;
            fix_lo_d = {WIDTH{1'b1}};
        end else begin
            fix_hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
            fix_lo_d = neg_q  ? -acc_lo_q : acc_lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            hl_q     <= 2'b00;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else begin
            hl_q <= 2'b00;
            case (state_q)
                // DONE's write pulse was issued on entry, so it accepts requests like IDLE
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start && !cancel) begin
                        if (!op[2]) begin
                            state_q  <= S_CALC;
                            busy_q   <= 1'b1;
                            cnt_q    <= CW'(WIDTH);
                            is_div_q <= op[1];
                            neg_q    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_q   <= op_signed & a[WIDTH-1];
                            divz_q   <= (b == '0);
                            a_q      <= a;
                            acc_hi_q <= '0;
                            opnd_q   <= op[1] ? abs_b : abs_a;
                            acc_lo_q <= op[1] ? abs_a : abs_b;
                        end else if (op == 3'b100) begin
                            hi_q <= a;
                            hl_q <= 2'b10;
                        end else if (op == 3'b101) begin
                            lo_q <= a;
                            hl_q <= 2'b01;
                        end
                    end
                end
                // WIDTH steps, then one extra cycle with the counter at 0 before FIX
                S_CALC: begin
                    if (cancel) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        acc_hi_q <= step_hi_d;
                        acc_lo_q <= step_lo_d;
                        cnt_q    <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        state_q <= S_DONE;
                        hi_q    <= fix_hi_d;
                        lo_q    <= fix_lo_d;
                        hl_q    <= 2'b11;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign hl_write = hl_q;

endmodule
